// File: rtl/hamming_encoder_tx.sv
// rtl/hamming_encoder_tx.sv - Hamming(7,4) encoder with error injection and FWFT output FIFO
module hamming_encoder_tx #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [3:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     inj_en,
   input  logic [2:0]               inj_pos,
   output logic [6:0]               out_code,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         word_count,
   output logic [CNT_W-1:0]         inj_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

   logic [6:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [6:0]    code;
   logic [6:0]    flip;
   logic [6:0]    stored;
   logic          inj_hit;
   logic          push;
   logic          pop;

   // Bit layout matches the decoder's syndrome positions: data at 2,4,5,6
   always_comb begin
      code    = '0;
      code[2] = in_data[0];
      code[4] = in_data[1];
      code[5] = in_data[2];
      code[6] = in_data[3];
      code[0] = in_data[0] ^ in_data[1] ^ in_data[3];
      code[1] = in_data[0] ^ in_data[2] ^ in_data[3];
      code[3] = in_data[1] ^ in_data[2] ^ in_data[3];
   end

   assign inj_hit = inj_en && (inj_pos != 3'd7);
   assign flip    = inj_hit ? (7'd1 << inj_pos) : 7'd0;
   assign stored  = code ^ flip;

   assign in_ready  = (level != FULL_LVL);
   assign out_valid = (level != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_code  = mem[rd_ptr];

   // Storage is intentionally not reset; out_code is don't-care while empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= stored;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         word_count <= '0;
         inj_count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (inj_hit) begin
               inj_count <= inj_count + CNT_W'(1);
            end
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + AW'(1);
            word_count <= word_count + CNT_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + ONE_LVL;
            2'b01:   level <= level - ONE_LVL;
            default: level <= level;
         endcase
      end
   end

endmodule
